clock24_core: RTL and testbench
===============================

CLOCK24_CORE -- requirements
Module: clock24_core

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 tick  input  1  one-cycle, one-per-second count enable.
REQ-005 setEnable  input  1  high freezes timekeeping; tick is ignored while high.
REQ-006 set24_propagate  input  1  one-cycle local load strobe.
REQ-007 set24_hours  input  5  local load hours, 0-23.
REQ-008 set24_minutes  input  6  local load minutes, 0-59.
REQ-009 in12_propagate  input  1  one-cycle load strobe from the 12-hour setter.
REQ-010 in12_isPM  input  1  PM flag of the 12-hour load.
REQ-011 in12_hours  input  5  12-hour load hours, 1-12.
REQ-012 in12_minutes  input  6  12-hour load minutes, 0-59.
REQ-013 hours / minutes / seconds  output  5/6/6  current 24-hour time, registered.
REQ-014 extern24_propagate  output  1  one-cycle strobe to the 12-hour clock.
REQ-015 extern24_hours / extern24_minutes  output  5/6  snapshot carried by extern24_propagate.
REQ-016 load_error  output  1  one-cycle pulse when a load is rejected.

Function
REQ-017 Load priority SHALL be: set24 load first, then in12 load, then tick.
- When set24 and in12 strobes coincide, the in12 strobe is dropped without error.
REQ-018 A set24 load with hours>23 or minutes>59 SHALL be rejected.
- Time is unchanged and load_error pulses on the next cycle.
REQ-019 An in12 load with hours 0 or >12, or minutes>59, SHALL be rejected the same way.
REQ-020 The in12 conversion SHALL be:
- 12 AM -> 0.
- 1-11 AM -> unchanged.
- 12 PM -> 12.
- 1-11 PM -> hours+12.
REQ-021 Any accepted load SHALL take effect in the cycle after the strobe and clear seconds to 0.
REQ-022 With setEnable low and no load, each tick SHALL advance seconds by one, with these carries:
- seconds 59 -> 0 and minutes increment.
- minutes 59 -> 0 and hours increment.
- 23:59:59 -> 00:00:00.
REQ-023 The transmitter FSM SHALL have states IDLE, SEND and GUARD.
- IDLE -> SEND on a request.
- SEND -> GUARD unconditionally.
- GUARD -> SEND if a request is pending, otherwise GUARD -> IDLE.
REQ-024 extern24_propagate SHALL be high exactly in SEND.
REQ-025 extern24_hours / extern24_minutes SHALL be loaded on entry to SEND with the time in effect that cycle, and held stable until the next SEND entry.
REQ-026 An accepted set24 load SHALL raise a transmit request.
- The request coincides with the time update.
- extern24_propagate is asserted 1 cycle after the time update.
REQ-027 An accepted in12 load SHALL never raise a transmit request (no echo).
REQ-028 in12_propagate arriving while the FSM is in SEND or GUARD SHALL be ignored, with no load and no error.
REQ-029 A request arriving in SEND or GUARD SHALL set a single pending flag.
- Multiple requests coalesce into one pending request.
- The snapshot taken on re-entry to SEND reflects the latest time.

Reset
REQ-030 On reset assertion the following SHALL be forced immediately:
- hours, minutes, seconds = 0.
- extern24_propagate, load_error = 0.
- extern24_hours, extern24_minutes = 0.
- FSM = IDLE; pending flag cleared.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer; no strobe is emitted after release.
REQ-032 The first tick after reset release SHALL yield 00:00:01.

Configuration
REQ-033 Macro CLOCK24_ROLLOVER_SYNC_EN:
- Defined: every tick-driven minutes 59->0 carry raises a transmit request, handled per REQ-023 to REQ-029 (hourly resync of the 12-hour clock).
- Undefined: only accepted set24 loads raise requests, and no rollover logic is synthesized.

Verification
REQ-034 set24 14:30 strobe -> hours=14, minutes=30, seconds=0 next cycle; extern24_propagate one cycle with 14/30 one cycle after that.
REQ-035 in12 12 AM:05 -> 00:05; in12 PM 7:45 -> 19:45; neither produces extern24_propagate.
REQ-036 Load 23:59, 60 ticks -> 00:00:00; with CLOCK24_ROLLOVER_SYNC_EN, extern24_propagate with 0/0 follows the 59->0 carry; without it, no strobe.
REQ-037 Simultaneous set24 10:00 and in12 PM 3:00 -> 10:00, one strobe; in12 in GUARD dropped; set24 in SEND -> second strobe after GUARD.
REQ-038 set24 hours=24, in12 hours=13 -> load_error pulse each, time unchanged; reset asserted in SEND -> all outputs 0, no strobe.

Source files
------------

// File: rtl/clock24_core_if.sv
// rtl/clock24_core_if.sv - load, time and 12-hour-link signal bundle for clock24_core
//
// Purpose: groups every non-clock, non-reset signal of clock24_core.
//   master : drives tick/setEnable and the set24/in12 load strobes, and
//            observes the time, the extern24 strobe/snapshot and load_error.
//   slave  : the clock core itself (mirror directions).
// Ports summary:
//   tick, setEnable                            count enable / freeze
//   set24_propagate/_hours/_minutes            local 24-hour load
//   in12_propagate/_isPM/_hours/_minutes       load from the 12-hour setter
//   hours, minutes, seconds                    current 24-hour time
//   extern24_propagate/_hours/_minutes         strobe + snapshot to 12-hour clock
//   load_error                                 rejected-load pulse
interface clock24_core_if;
  logic       tick;
  logic       setEnable;
  logic       set24_propagate;
  logic [4:0] set24_hours;
  logic [5:0] set24_minutes;
  logic       in12_propagate;
  logic       in12_isPM;
  logic [4:0] in12_hours;
  logic [5:0] in12_minutes;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       extern24_propagate;
  logic [4:0] extern24_hours;
  logic [5:0] extern24_minutes;
  logic       load_error;

  modport master (
    output tick, setEnable,
    output set24_propagate, set24_hours, set24_minutes,
    output in12_propagate, in12_isPM, in12_hours, in12_minutes,
    input  hours, minutes, seconds,
    input  extern24_propagate, extern24_hours, extern24_minutes,
    input  load_error
  );

  modport slave (
    input  tick, setEnable,
    input  set24_propagate, set24_hours, set24_minutes,
    input  in12_propagate, in12_isPM, in12_hours, in12_minutes,
    output hours, minutes, seconds,
    output extern24_propagate, extern24_hours, extern24_minutes,
    output load_error
  );
endinterface

// File: rtl/clock24_core.sv
// rtl/clock24_core.sv - 24-hour time-of-day counter with 12-hour clock link
//
// Purpose: keeps hours/minutes/seconds, accepts loads from a local 24-hour
//   setter (set24) and from a 12-hour setter (in12), and forwards accepted
//   set24 loads to the 12-hour clock through a SEND/GUARD strobe transmitter.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    clock24_core_if.slave (see interface file for signal list)
// Option macro: CLOCK24_ROLLOVER_SYNC_EN - when defined, every tick-driven
//   minutes 59->0 carry also requests a transmit (hourly resync of the
//   12-hour clock).
module clock24_core (
  input  logic           clk,
  input  logic           reset,
  clock24_core_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  logic [1:0] state_q;
  logic       pend_q;
  logic       req_q;
  logic [4:0] hours_q;
  logic [5:0] minutes_q;
  logic [5:0] seconds_q;
  logic [4:0] ext_hours_q;
  logic [5:0] ext_minutes_q;
  logic       load_error_q;

  logic       s24_ok;
  logic       i12_ok;
  logic       in12_live;
  logic [4:0] i12_h24;

  logic [4:0] n_h;
  logic [5:0] n_m;
  logic [5:0] n_s;
  logic       err_d;
  logic       req_d;

  assign s24_ok = (bus.set24_hours <= 5'd23) && (bus.set24_minutes <= 6'd59);
  assign i12_ok = (bus.in12_hours != 5'd0) && (bus.in12_hours <= 5'd12) &&
                  (bus.in12_minutes <= 6'd59);

  // 12 maps to 0 first, then PM adds 12: covers 12AM->0 and 12PM->12.
  assign i12_h24 = ((bus.in12_hours == 5'd12) ? 5'd0 : bus.in12_hours) +
                   (bus.in12_isPM ? 5'd12 : 5'd0);

  // in12 loads are only honoured while the link is quiet; otherwise the
  // 12-hour side may be loading from our own in-flight strobe.
  assign in12_live = bus.in12_propagate && (state_q == ST_IDLE);

  always_comb begin
    n_h   = hours_q;
    n_m   = minutes_q;
    n_s   = seconds_q;
    err_d = 1'b0;
    req_d = 1'b0;
    if (bus.set24_propagate) begin
      // set24 wins outright; a coincident in12 strobe is dropped silently.
      if (s24_ok) begin
        n_h   = bus.set24_hours;
        n_m   = bus.set24_minutes;
        n_s   = 6'd0;
        req_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (in12_live) begin
      // No transmit request here: echoing would bounce back to the sender.
      if (i12_ok) begin
        n_h = i12_h24;
        n_m = bus.in12_minutes;
        n_s = 6'd0;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.tick && !bus.setEnable) begin
      if (seconds_q == 6'd59) begin
        n_s = 6'd0;
        if (minutes_q == 6'd59) begin
          n_m = 6'd0;
          n_h = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
`ifdef CLOCK24_ROLLOVER_SYNC_EN
          req_d = 1'b1;
`endif
        end else begin
          n_m = minutes_q + 6'd1;
        end
      end else begin
        n_s = seconds_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hours_q       <= 5'd0;
      minutes_q     <= 6'd0;
      seconds_q     <= 6'd0;
      load_error_q  <= 1'b0;
      req_q         <= 1'b0;
      state_q       <= ST_IDLE;
      pend_q        <= 1'b0;
      ext_hours_q   <= 5'd0;
      ext_minutes_q <= 6'd0;
    end else begin
      hours_q      <= n_h;
      minutes_q    <= n_m;
      seconds_q    <= n_s;
      load_error_q <= err_d;
      // req_q is high in the cycle the new time is visible, so the snapshot
      // taken on the following edge captures the freshly loaded value.
      req_q        <= req_d;
      case (state_q)
        ST_IDLE: begin
          if (req_q) begin
            state_q       <= ST_SEND;
            ext_hours_q   <= hours_q;
            ext_minutes_q <= minutes_q;
          end
        end
        ST_SEND: begin
          state_q <= ST_GUARD;
          if (req_q) pend_q <= 1'b1;
        end
        ST_GUARD: begin
          if (pend_q || req_q) begin
            state_q       <= ST_SEND;
            pend_q        <= 1'b0;
            ext_hours_q   <= hours_q;
            ext_minutes_q <= minutes_q;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hours              = hours_q;
  assign bus.minutes            = minutes_q;
  assign bus.seconds            = seconds_q;
  assign bus.load_error         = load_error_q;
  assign bus.extern24_propagate = (state_q == ST_SEND);
  assign bus.extern24_hours     = ext_hours_q;
  assign bus.extern24_minutes   = ext_minutes_q;

endmodule

// File: tb/tb_clock24_core.sv
// tb/tb_clock24_core.sv - self-checking bench for clock24_core
module tb_clock24_core;
  logic clk = 1'b0;
  logic reset = 1'b1;

  clock24_core_if bus ();

  clock24_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: time as seconds-of-day; link as cycles since last strobe.
  int m_tod   = 0;
  int m_since = 99;
  int m_xh    = 0;
  int m_xm    = 0;
  bit m_err   = 1'b0;
  bit m_req   = 1'b0;
  bit m_pend  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_tod = 0; m_since = 99; m_xh = 0; m_xm = 0;
    m_err = 1'b0; m_req = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_update();
    bit busy, go, nreq, nerr;
    int h, mi;
    if (reset) begin
      model_reset();
      return;
    end
    busy = (m_since <= 1);
    go = (m_req && m_since >= 2) || (m_since == 1 && (m_pend || m_req));
    if (go) begin
      m_xh = m_tod / 3600;
      m_xm = (m_tod / 60) % 60;
      m_pend = 1'b0;
      m_since = 0;
    end else begin
      if (m_since == 0) m_pend = m_pend | m_req;
      if (m_since < 99) m_since++;
    end
    nreq = 1'b0;
    nerr = 1'b0;
    if (bus.set24_propagate) begin
      h = int'(bus.set24_hours);
      mi = int'(bus.set24_minutes);
      if (h <= 23 && mi <= 59) begin
        m_tod = h * 3600 + mi * 60;
        nreq = 1'b1;
      end else nerr = 1'b1;
    end else if (bus.in12_propagate && !busy) begin
      h = int'(bus.in12_hours);
      mi = int'(bus.in12_minutes);
      if (h >= 1 && h <= 12 && mi <= 59)
        m_tod = ((h % 12) + (bus.in12_isPM ? 12 : 0)) * 3600 + mi * 60;
      else nerr = 1'b1;
    end else if (bus.tick && !bus.setEnable) begin
      m_tod = (m_tod + 1) % 86400;
`ifdef CLOCK24_ROLLOVER_SYNC_EN
      if (m_tod % 3600 == 0) nreq = 1'b1;
`endif
    end
    m_req = nreq;
    m_err = nerr;
  endtask

  always @(negedge clk) begin
    chk("hours", int'(bus.hours), m_tod / 3600);
    chk("minutes", int'(bus.minutes), (m_tod / 60) % 60);
    chk("seconds", int'(bus.seconds), m_tod % 60);
    chk("load_error", int'(bus.load_error), int'(m_err));
    chk("ext_prop", int'(bus.extern24_propagate), (m_since == 0) ? 1 : 0);
    chk("ext_hours", int'(bus.extern24_hours), m_xh);
    chk("ext_minutes", int'(bus.extern24_minutes), m_xm);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_update();
      #1;
    end
  endtask

  task automatic set24(input int h, input int m);
    bus.set24_hours = 5'(h);
    bus.set24_minutes = 6'(m);
    bus.set24_propagate = 1'b1;
    cyc();
    bus.set24_propagate = 1'b0;
  endtask

  task automatic in12(input int h, input bit pm, input int m);
    bus.in12_hours = 5'(h);
    bus.in12_isPM = pm;
    bus.in12_minutes = 6'(m);
    bus.in12_propagate = 1'b1;
    cyc();
    bus.in12_propagate = 1'b0;
  endtask

  initial begin
    bus.tick = 1'b0; bus.setEnable = 1'b0;
    bus.set24_propagate = 1'b0; bus.set24_hours = '0; bus.set24_minutes = '0;
    bus.in12_propagate = 1'b0; bus.in12_isPM = 1'b0;
    bus.in12_hours = '0; bus.in12_minutes = '0;

    cyc(3);
    chk("rst_hours", int'(bus.hours), 0);
    chk("rst_ext_prop", int'(bus.extern24_propagate), 0);
    reset = 1'b0;
    cyc(2);

    bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
    chk("first_tick_sec", int'(bus.seconds), 1);
    chk("first_tick_min", int'(bus.minutes), 0);
    cyc(2);

    set24(14, 30);
    chk("s24_hours", int'(bus.hours), 14);
    chk("s24_minutes", int'(bus.minutes), 30);
    chk("s24_seconds", int'(bus.seconds), 0);
    chk("s24_no_strobe_yet", int'(bus.extern24_propagate), 0);
    cyc();
    chk("s24_strobe", int'(bus.extern24_propagate), 1);
    chk("s24_ext_h", int'(bus.extern24_hours), 14);
    chk("s24_ext_m", int'(bus.extern24_minutes), 30);
    cyc();
    chk("s24_strobe_end", int'(bus.extern24_propagate), 0);
    cyc(3);

    in12(12, 1'b0, 5);
    chk("i12_am12_h", int'(bus.hours), 0);
    chk("i12_am12_m", int'(bus.minutes), 5);
    cyc(2);
    in12(7, 1'b1, 45);
    chk("i12_pm7_h", int'(bus.hours), 19);
    chk("i12_pm7_m", int'(bus.minutes), 45);
    cyc(3);

    bus.setEnable = 1'b1; bus.tick = 1'b1; cyc(2);
    bus.tick = 1'b0; bus.setEnable = 1'b0;
    chk("frozen_sec", int'(bus.seconds), 0);

    set24(23, 59);
    cyc(3);
    repeat (60) begin
      bus.tick = 1'b1; cyc(); bus.tick = 1'b0; cyc();
    end
    chk("wrap_h", int'(bus.hours), 0);
    chk("wrap_m", int'(bus.minutes), 0);
    chk("wrap_s", int'(bus.seconds), 0);
`ifdef CLOCK24_ROLLOVER_SYNC_EN
    chk("roll_strobe", int'(bus.extern24_propagate), 1);
    chk("roll_ext_h", int'(bus.extern24_hours), 0);
`else
    chk("roll_no_strobe", int'(bus.extern24_propagate), 0);
`endif
    cyc(3);

    bus.in12_hours = 5'd3; bus.in12_isPM = 1'b1; bus.in12_minutes = 6'd0;
    bus.in12_propagate = 1'b1;
    set24(10, 0);
    bus.in12_propagate = 1'b0;
    chk("both_h", int'(bus.hours), 10);
    chk("both_m", int'(bus.minutes), 0);
    cyc();
    chk("both_strobe", int'(bus.extern24_propagate), 1);
    cyc();
    in12(5, 1'b1, 0);
    chk("guard_in12_h", int'(bus.hours), 10);
    chk("guard_in12_err", int'(bus.load_error), 0);
    cyc(3);

    set24(8, 0);
    cyc();
    chk("send1", int'(bus.extern24_propagate), 1);
    set24(12, 34);
    chk("guard_gap", int'(bus.extern24_propagate), 0);
    chk("reload_h", int'(bus.hours), 12);
    cyc();
    chk("send2", int'(bus.extern24_propagate), 1);
    chk("send2_h", int'(bus.extern24_hours), 12);
    chk("send2_m", int'(bus.extern24_minutes), 34);
    cyc(3);

    set24(24, 0);
    chk("err_s24h", int'(bus.load_error), 1);
    chk("err_s24h_time", int'(bus.hours), 12);
    cyc();
    chk("err_clear", int'(bus.load_error), 0);
    in12(13, 1'b0, 0);
    chk("err_i12h", int'(bus.load_error), 1);
    chk("err_i12h_time", int'(bus.minutes), 34);
    set24(5, 60);
    in12(0, 1'b1, 10);
    chk("err_i12zero", int'(bus.load_error), 1);
    cyc(3);

    set24(8, 15);
    cyc();
    chk("pre_rst_send", int'(bus.extern24_propagate), 1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_send_prop", int'(bus.extern24_propagate), 0);
    chk("rst_send_h", int'(bus.hours), 0);
    chk("rst_send_xh", int'(bus.extern24_hours), 0);
    cyc(2);
    reset = 1'b0;
    cyc(4);
    chk("post_rst_quiet", int'(bus.extern24_propagate), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
